// File: rtl/neighbor_accumulation_buffer.sv
// Banked signed accumulation store fed by the neighbour scatter stage; drains the
// tile row-major over valid/ready, clearing each entry as it is read.
module neighbor_accumulation_buffer #(
    parameter int BANK_COUNT = 32,
    parameter int TILE_SIZE  = 256,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [$clog2(TILE_SIZE)-1:0]   buffer_row_write    [BANK_COUNT],
    input  logic [$clog2(TILE_SIZE)-1:0]   buffer_column_write [BANK_COUNT],
    input  logic [7:0]                     buffer_data_write   [BANK_COUNT],
    input  logic [BANK_COUNT-1:0]          buffer_write_enable,
    input  logic                           drain_start,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [$clog2(TILE_SIZE)-1:0]   out_row,
    output logic [$clog2(TILE_SIZE)-1:0]   out_column,
    output logic [ACC_WIDTH-1:0]           out_data,
    output logic                           busy,
    output logic                           drain_done,
    output logic                           write_while_busy
);

    localparam int AW            = $clog2(TILE_SIZE);
    localparam int DEPTH         = TILE_SIZE * TILE_SIZE / BANK_COUNT;
    localparam int DW            = $clog2(DEPTH);
    localparam int COLS_PER_BANK = TILE_SIZE / BANK_COUNT;
    localparam int BW            = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;
    localparam logic [AW-1:0] LAST = AW'(TILE_SIZE - 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FLUSH, ST_DRAIN} state_t;

    function automatic logic [DW-1:0] bank_addr(input logic [AW-1:0] row, input logic [AW-1:0] col);
        return DW'(int'(row) * COLS_PER_BANK + int'(col) / BANK_COUNT);
    endfunction

    function automatic logic [BW-1:0] bank_of(input logic [AW-1:0] row, input logic [AW-1:0] col);
        return BW'((int'(col) + 3 * int'(row)) % BANK_COUNT);
    endfunction

    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a, input logic [7:0] d);
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH-7){d[7]}}, d};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return s[ACC_WIDTH-1:0];
    endfunction

    state_t               state;
    logic [DW-1:0]        init_cnt;
    logic                 flush_cnt;
    logic [AW-1:0]        iss_row, iss_col;
    logic                 iss_done;
    logic                 issue;
    logic [BW-1:0]        iss_bank;
    logic [DW-1:0]        iss_addr;
    logic                 rd_pending;
    logic [AW-1:0]        rd_row_q, rd_col_q;
    logic [BW-1:0]        rd_bank_q;
    logic                 skid_valid;
    logic [AW-1:0]        skid_row, skid_col;
    logic [ACC_WIDTH-1:0] skid_data;
    logic [ACC_WIDTH-1:0] bank_rdata [BANK_COUNT];
    logic                 fire, last_fire;

    assign iss_bank = bank_of(iss_row, iss_col);
    assign iss_addr = bank_addr(iss_row, iss_col);
    // A new read is only issued when the skid can absorb it if the consumer stalls.
    assign issue = (state == ST_DRAIN) && !iss_done && !skid_valid && (out_ready || !rd_pending);

    assign out_valid  = skid_valid | rd_pending;
    assign out_row    = skid_valid ? skid_row  : (rd_pending ? rd_row_q : '0);
    assign out_column = skid_valid ? skid_col  : (rd_pending ? rd_col_q : '0);
    assign out_data   = skid_valid ? skid_data : (rd_pending ? bank_rdata[rd_bank_q] : '0);
    assign fire       = out_valid & out_ready;
    assign last_fire  = fire && (out_row == LAST) && (out_column == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_INIT;
            busy             <= 1'b1;
            init_cnt         <= '0;
            flush_cnt        <= 1'b0;
            iss_row          <= '0;
            iss_col          <= '0;
            iss_done         <= 1'b0;
            rd_pending       <= 1'b0;
            rd_row_q         <= '0;
            rd_col_q         <= '0;
            rd_bank_q        <= '0;
            skid_valid       <= 1'b0;
            skid_row         <= '0;
            skid_col         <= '0;
            skid_data        <= '0;
            drain_done       <= 1'b0;
            write_while_busy <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            if (busy && |buffer_write_enable)
                write_while_busy <= 1'b1;

            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == DW'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (drain_start) begin
                        state     <= ST_FLUSH;
                        busy      <= 1'b1;
                        flush_cnt <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state    <= ST_DRAIN;
                        iss_row  <= '0;
                        iss_col  <= '0;
                        iss_done <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (issue) begin
                        if (iss_row == LAST && iss_col == LAST) begin
                            iss_done <= 1'b1;
                        end else if (iss_col == LAST) begin
                            iss_col <= '0;
                            iss_row <= iss_row + 1'b1;
                        end else begin
                            iss_col <= iss_col + 1'b1;
                        end
                    end
                    if (last_fire) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        drain_done <= 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase

            rd_pending <= issue;
            if (issue) begin
                rd_row_q  <= iss_row;
                rd_col_q  <= iss_col;
                rd_bank_q <= iss_bank;
            end

            if (skid_valid) begin
                if (out_ready)
                    skid_valid <= 1'b0;
            end else if (rd_pending && !out_ready) begin
                skid_valid <= 1'b1;
                skid_row   <= rd_row_q;
                skid_col   <= rd_col_q;
                skid_data  <= bank_rdata[rd_bank_q];
            end
        end
    end

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        logic [ACC_WIDTH-1:0] mem [DEPTH];
        logic [ACC_WIDTH-1:0] rdata, fwd_val, operand, sum, wdata;
        logic [DW-1:0]        in_addr, req_addr, waddr, raddr;
        logic [7:0]           req_data;
        logic                 req_valid, fwd_hit, wr_ok, drain_hit, we, re;

        assign in_addr   = bank_addr(buffer_row_write[b], buffer_column_write[b]);
        assign wr_ok     = buffer_write_enable[b] && (state == ST_IDLE);
        assign drain_hit = issue && (iss_bank == BW'(b));
        assign operand   = fwd_hit ? fwd_val : rdata;
        assign sum       = sat_add(operand, req_data);

        // Entries are cleared when their drain read is issued; any abort goes through
        // reset and INIT, so this is indistinguishable from clearing at the handshake.
        always_comb begin
            we    = 1'b0;
            waddr = req_addr;
            wdata = sum;
            if (state == ST_INIT) begin
                we    = 1'b1;
                waddr = init_cnt;
                wdata = '0;
            end else if (drain_hit) begin
                we    = 1'b1;
                waddr = iss_addr;
                wdata = '0;
            end else if (req_valid) begin
                we = 1'b1;
            end
            re    = drain_hit | wr_ok;
            raddr = drain_hit ? iss_addr : in_addr;
        end

        always_ff @(posedge clk) begin
            if (we)
                mem[waddr] <= wdata;
            if (re)
                rdata <= mem[raddr];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                req_valid <= 1'b0;
                req_addr  <= '0;
                req_data  <= '0;
                fwd_hit   <= 1'b0;
                fwd_val   <= '0;
            end else begin
                req_valid <= wr_ok;
                if (wr_ok) begin
                    req_addr <= in_addr;
                    req_data <= buffer_data_write[b];
                end
                fwd_hit <= wr_ok && req_valid && (in_addr == req_addr);
                fwd_val <= sum;
            end
        end

        assign bank_rdata[b] = rdata;
    end

endmodule

// File: tb/tb_neighbor_accumulation_buffer.sv
// Directed bench for neighbor_accumulation_buffer on a reduced 8x8 tile, 4 banks,
// 10-bit accumulators (DEPTH = 16, 64 beats per drain).
module tb_neighbor_accumulation_buffer;

    localparam int NB    = 4;
    localparam int TS    = 8;
    localparam int AWD   = 3;
    localparam int ACCW  = 10;
    localparam int DEPTH = 16;
    localparam int BEATS = TS * TS;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [AWD-1:0]   wr_row  [NB];
    logic [AWD-1:0]   wr_col  [NB];
    logic [7:0]       wr_data [NB];
    logic [NB-1:0]    wr_en;
    logic             drain_start = 1'b0;
    logic             out_ready = 1'b1;
    logic             out_valid;
    logic [AWD-1:0]   out_row, out_column;
    logic [ACCW-1:0]  out_data;
    logic             busy, drain_done, write_while_busy;

    int errors = 0;
    int checks = 0;
    int exp_val [BEATS];

    always #5 clk = ~clk;

    neighbor_accumulation_buffer #(
        .BANK_COUNT(NB),
        .TILE_SIZE (TS),
        .ACC_WIDTH (ACCW)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .buffer_row_write   (wr_row),
        .buffer_column_write(wr_col),
        .buffer_data_write  (wr_data),
        .buffer_write_enable(wr_en),
        .drain_start        (drain_start),
        .out_ready          (out_ready),
        .out_valid          (out_valid),
        .out_row            (out_row),
        .out_column         (out_column),
        .out_data           (out_data),
        .busy               (busy),
        .drain_done         (drain_done),
        .write_while_busy   (write_while_busy)
    );

    task automatic clear_lanes();
        for (int i = 0; i < NB; i++) begin
            wr_row[i]  = '0;
            wr_col[i]  = '0;
            wr_data[i] = '0;
        end
        wr_en = '0;
    endtask

    task automatic put(input int r, input int c, input int d);
        int b;
        b = (c + 3 * r) % NB;
        wr_en[b]   = 1'b1;
        wr_row[b]  = AWD'(r);
        wr_col[b]  = AWD'(c);
        wr_data[b] = 8'(d);
    endtask

    task automatic tick();
        @(negedge clk);
        clear_lanes();
    endtask

    task automatic clear_exp();
        for (int i = 0; i < BEATS; i++) exp_val[i] = 0;
    endtask

    task automatic release_and_init();
        int cnt;
        clear_lanes();
        drain_start = 1'b0;
        out_ready   = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != DEPTH)
            $display("FAIL init_busy_len: busy cycles=%0d, want %0d", cnt, DEPTH);
        if (cnt != DEPTH) errors++;
    endtask

    // stall: pseudo-random out_ready; abort_at: pull reset when that many beats accepted;
    // misuse: write and drain_start while draining.
    task automatic run_drain(input bit stall, input int abort_at, input bit misuse);
        int beats, done_cnt, first_k, last_k, done_k;
        bit held;
        logic [AWD-1:0]  h_row, h_col;
        logic [ACCW-1:0] h_data;
        beats = 0; done_cnt = 0; first_k = -1; last_k = -1; done_k = -1; held = 1'b0;
        h_row = '0; h_col = '0; h_data = '0;
        drain_start = 1'b1;
        @(negedge clk);
        drain_start = 1'b0;
        clear_lanes();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: busy=%b, want 1", busy);
        end
        for (int k = 0; k < 600; k++) begin
            if (abort_at >= 0 && beats == abort_at) begin
                reset_n = 1'b0;
                #1;
                checks++;
                if (out_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_reset: out_valid=%b busy=%b, want 0 1", out_valid, busy);
                end
                return;
            end
            if (drain_done === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
            if (last_k >= 0 && k == last_k + 1) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_fall: busy=%b, want 0", busy);
                end
            end
            if (misuse && k == 10) begin
                put(4, 4, 50);
                drain_start = 1'b1;
            end else if (misuse && k == 11) begin
                clear_lanes();
                drain_start = 1'b0;
            end
            out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_row !== h_row || out_column !== h_col || out_data !== h_data) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%b (%0d,%0d)=%0d, want v=1 (%0d,%0d)=%0d",
                             out_valid, out_row, out_column, $signed(out_data), h_row, h_col, $signed(h_data));
                end
            end
            held = 1'b0;
            if (out_valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                if (out_ready) begin
                    checks++;
                    if (beats >= BEATS || out_row !== AWD'(beats / TS) || out_column !== AWD'(beats % TS)
                        || out_data !== ACCW'(exp_val[beats % BEATS])) begin
                        errors++;
                        $display("FAIL beat%0d: got (%0d,%0d)=%0d, want (%0d,%0d)=%0d", beats,
                                 out_row, out_column, $signed(out_data), beats / TS, beats % TS,
                                 exp_val[beats % BEATS]);
                    end
                    beats++;
                    if (beats == BEATS) last_k = k;
                end else begin
                    held   = 1'b1;
                    h_row  = out_row;
                    h_col  = out_column;
                    h_data = out_data;
                end
            end
            if (last_k >= 0 && k >= last_k + 3) break;
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (beats != BEATS) begin
            errors++;
            $display("FAIL beat_count: got %0d, want %0d", beats, BEATS);
        end
        checks++;
        if (done_cnt != 1 || done_k != last_k + 1) begin
            errors++;
            $display("FAIL drain_done: pulses=%0d at k=%0d, want 1 at k=%0d", done_cnt, done_k, last_k + 1);
        end
        if (!stall) begin
            checks++;
            if (first_k != 3 || last_k != 3 + BEATS - 1) begin
                errors++;
                $display("FAIL drain_timing: first=%0d last=%0d, want 3 %0d", first_k, last_k, 3 + BEATS - 1);
            end
        end
        clear_exp();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_row !== '0 || out_column !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_out: v=%b (%0d,%0d)=%0d, want 0 (0,0)=0", out_valid, out_row, out_column, out_data);
        end
        checks++;
        if (drain_done !== 1'b0 || write_while_busy !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: done=%b wwb=%b busy=%b, want 0 0 1", drain_done, write_while_busy, busy);
        end
        release_and_init();
    endtask

    task automatic test_init_drain();
        clear_exp();
        run_drain(1'b0, -1, 1'b0);
    endtask

    task automatic test_accumulate();
        clear_exp();
        put(3, 0, 3);
        tick();
        tick();
        put(3, 0, 4);
        tick();
        put(0, 3, 5); put(1, 1, -7);
        tick();
        put(0, 3, 5);
        tick();
        put(0, 3, 5);
        tick();
        put(0, 3, 5); put(7, 7, 1);
        exp_val[3]  = 20;
        exp_val[9]  = -7;
        exp_val[24] = 7;
        exp_val[63] = 1;
        run_drain(1'b0, -1, 1'b0);
    endtask

    task automatic test_saturation_backpressure();
        clear_exp();
        for (int i = 0; i < 5; i++) begin
            put(2, 2, 127);
            put(2, 3, -128);
            put(6, 0, (i < 4) ? 127 : 3);
            tick();
        end
        exp_val[18] = 511;
        exp_val[19] = -512;
        exp_val[48] = 511;
        run_drain(1'b1, -1, 1'b0);
    endtask

    task automatic test_clear_on_read();
        clear_exp();
        put(5, 6, 9);
        tick();
        exp_val[46] = 9;
        run_drain(1'b0, -1, 1'b0);
        run_drain(1'b0, -1, 1'b0);
    endtask

    task automatic test_misuse();
        clear_exp();
        run_drain(1'b0, -1, 1'b1);
        checks++;
        if (write_while_busy !== 1'b1) begin
            errors++;
            $display("FAIL wwb_set: got %b, want 1", write_while_busy);
        end
        run_drain(1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        clear_exp();
        put(6, 1, 3);
        tick();
        exp_val[49] = 3;
        run_drain(1'b0, 20, 1'b0);
        release_and_init();
        checks++;
        if (write_while_busy !== 1'b0) begin
            errors++;
            $display("FAIL wwb_cleared: got %b, want 0", write_while_busy);
        end
        clear_exp();
        run_drain(1'b0, -1, 1'b0);
    endtask

    initial begin
        clear_lanes();
        test_reset();
        test_init_drain();
        test_accumulate();
        test_saturation_backpressure();
        test_clear_on_read();
        test_misuse();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/neighbor_accumulation_buffer.md
# neighbor_accumulation_buffer

- Banked accumulation store that receives the per-bank write streams from the neighbour-input scatter stage.
- Each bank does a pipelined signed read-modify-write accumulate of incoming 8-bit partial values into ACC_WIDTH-bit entries.
- On request it drains the whole TILE_SIZE×TILE_SIZE tile in row-major order over a valid/ready stream, clearing each entry as it is read.
- It sits directly downstream of the neighbour-input scatter stage and upstream of output writeback.

## Interface
- BANK_COUNT, 32, number of banks; power of two; must divide TILE_SIZE
- TILE_SIZE, 256, tile edge; row/column width AW = $clog2(TILE_SIZE)
- ACC_WIDTH, 16, signed accumulator width (≥ 9)
- clk  in  1  single clock; all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- buffer_row_write[BANK_COUNT]  in  AW  per-bank row
- buffer_column_write[BANK_COUNT]  in  AW  per-bank column
- buffer_data_write[BANK_COUNT]  in  8  per-bank signed partial value
- buffer_write_enable[BANK_COUNT]  in  1  per-bank write strobe
- drain_start  in  1  one-cycle drain request
- out_ready  in  1  downstream ready
- out_valid  out  1  drain beat valid
- out_row / out_column  out  AW  coordinate of the current beat
- out_data  out  ACC_WIDTH  accumulated value, signed
- busy  out  1  high in INIT, FLUSH and DRAIN; upstream must not write while it is high
- drain_done  out  1  one-cycle pulse after the final drain beat
- write_while_busy  out  1  sticky error flag; cleared only by reset

## Operation
- Mapping: bank = (column + 3·row) mod BANK_COUNT; in-bank address = {row, column / BANK_COUNT}; DEPTH = TILE_SIZE²/BANK_COUNT words per bank.
- The write stream arrives pre-banked; the input bank index is trusted and not recomputed.
- Accumulate: entry = sat(entry + sign_extend(data)).
  - Saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; never wraps.
- Per-bank pipeline has two stages:
  - S0 registers the request and issues a synchronous read.
  - S1 adds and writes back.
- Forwarding: if S1 is writing the same bank address that S0 is reading, S0 uses the S1 result. Back-to-back writes to one address must sum exactly.
- FSM:
  - INIT: entered on reset. A counter 0..DEPTH-1 writes zero to all banks in parallel. Exits to IDLE after DEPTH cycles.
  - IDLE: writes accepted. On drain_start, go to FLUSH.
  - FLUSH: exactly 2 cycles so the pipeline empties, then go to DRAIN.
  - DRAIN: scans (row, column) row-major from (0,0) to (TILE_SIZE-1, TILE_SIZE-1).
    - Reads bank(row, col) at its address; each accepted beat writes zero back to that location.
    - After the last handshake, go to IDLE and pulse drain_done.
- drain_start outside IDLE is ignored.
- A write strobe while busy=1 is dropped and sets write_while_busy.
- A write and drain_start in the same IDLE cycle: the write is accepted and included in the drain.
- Memory contents are not reset directly; INIT guarantees all entries are zero after every reset.

## Timing
- Reset values: out_valid=0, out_row=0, out_column=0, out_data=0, drain_done=0, write_while_busy=0, busy=1 (INIT).
- Deasserting reset_n mid-drain or mid-accumulate aborts everything and restarts INIT. No partial beat is emitted.
- busy rises the cycle after drain_start is sampled and falls the cycle after the final handshake.
- Write latency:
  - A strobe at cycle t is committed to the array at the edge ending cycle t+1.
  - Read-after-write to the same address from cycle t+1 onward is exact via forwarding.
- Drain stream:
  - out_valid is first asserted 1 cycle after FLUSH ends (one-cycle read latency).
  - Throughput is 1 beat/cycle while out_ready=1.
  - out_row, out_column and out_data hold stable while out_valid && !out_ready; a skid register absorbs the in-flight read.
- Total drain: TILE_SIZE² beats. drain_done is asserted the cycle after the last beat's handshake.

## Test plan
- Reset/init: release reset_n; busy=1 for exactly DEPTH=2048 cycles, then 0. An immediate drain returns 65536 beats of out_data=0 in order (0,0),(0,1),…,(255,255).
- Accumulate with forwarding: bank 3 writes (0,3)=+5 for 4 consecutive cycles. Also bank 4 writes (1,1)=-7 once (bank = 1+3 = 4). Drain gives (0,3)=20, (1,1)=-7, all others 0.
- Saturation: 300 writes of +127 to (2,2) give out_data=32767. 300 writes of -128 to (2,3) give -32768.
- Backpressure: toggle out_ready pseudo-randomly during drain. No beat is lost or duplicated, held outputs stay stable, and drain_done fires once after beat (255,255).
- Clear-on-read: accumulate (5,10)=+9, drain, then drain again. The second drain returns all zeros.
- Misuse and reset mid-drain:
  - A write during DRAIN sets write_while_busy=1 and the value is absent from every later drain.
  - drain_start during DRAIN is ignored.
  - reset_n low at beat 100 gives out_valid=0 immediately, then INIT restarts.
